rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter N_CH, 4, number of input channels (2..16).
REQ-002 SHALL have parameter WIDTH, 8, data bits per channel.
REQ-003 SHALL have parameter CW, $clog2(N_CH), channel-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  N_CH  per-channel request.
REQ-007 SHALL have port in_data  input  N_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  N_CH  per-channel end-of-packet marker.
REQ-009 SHALL have port in_ready  output  N_CH  per-channel accept, at most one bit high.
REQ-010 SHALL have port out_valid  output  1  output register holds a word.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-012 SHALL have port out_ch  output  CW  source channel of out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-014 SHALL hold one output register; load enable = !out_valid || out_ready.
REQ-015 SHALL assert in_ready[g] only for granted channel g, and only when load enable is high and in_valid[g]=1.
REQ-016 SHALL leave in_ready all zero when no channel is valid or load enable is low.
REQ-017 SHALL transfer on in_valid[g]&&in_ready[g]: out_data <= word g, out_ch <= g, out_valid <= 1 next edge (latency 1 cycle).
REQ-018 SHALL clear out_valid on out_valid&&out_ready with no simultaneous transfer; simultaneous accept and load keeps out_valid=1 with the new word (full throughput, 1 word/cycle).
REQ-019 SHALL keep out_data/out_ch/out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL grant round-robin: search starts at ptr, wraps from N_CH-1 to 0, first valid channel wins.
REQ-021 SHALL update ptr to (g+1) mod N_CH after each transfer; ptr unchanged when no transfer.
REQ-022 SHALL compute grant combinationally from in_valid and ptr; in_ready does not depend on in_data.
REQ-023 SHALL guarantee any channel held valid is granted within N_CH transfers.
REQ-024 SHALL treat in_valid deassertion before transfer as request withdrawal; no word is captured.

Reset
REQ-025 SHALL, on rst=1, immediately clear out_valid=0, out_data=0, out_ch=0, ptr=0, lock state idle, in_ready=0.
REQ-026 SHALL discard any word in the output register when rst asserts mid-operation; first grant after release searches from channel 0.

Configuration
REQ-027 SHALL support macro RR_MUX_LOCK_EN.
REQ-028 SHALL, with RR_MUX_LOCK_EN defined, hold grant on channel g after a transfer with in_last[g]=0 (states IDLE -> LOCKED(g)), ptr frozen, other channels ignored even if g goes invalid.
REQ-029 SHALL, with RR_MUX_LOCK_EN defined, return to IDLE and set ptr=(g+1) mod N_CH on the transfer with in_last[g]=1.
REQ-030 SHALL, without RR_MUX_LOCK_EN, ignore in_last and re-arbitrate every transfer per REQ-020/021.

Verification (N_CH=4, WIDTH=8)
REQ-031 SHALL check: in_valid=4'b1111, data ch i=8'hA0+i, out_ready=1 -> out_ch sequence 0,1,2,3,0 every cycle, out_data A0,A1,A2,A3,A0.
REQ-032 SHALL check: single word on ch2 (8'h5C), out_ready=0 for 5 cycles -> out_valid=1, out_data=8'h5C held, in_ready=0 while stalled; released after out_ready=1.
REQ-033 SHALL check: ptr=1, in_valid=4'b0001 -> grant wraps to ch0, next ptr=1.
REQ-034 SHALL check: rst pulsed asynchronously while out_valid=1 -> out_valid=0 before next clk edge; next grant from ch0 with all valid.
REQ-035 SHALL check (LOCK_EN): ch1 sends 3 words, in_last on third, ch0/ch3 valid -> out_ch 1,1,1 then 3,0.
REQ-036 SHALL check (no LOCK_EN): same stimulus -> out_ch interleaves 1,3,0,1.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin N_CH-channel mux into a single registered output slot.
// Define RR_MUX_LOCK_EN to hold the grant on one channel until its in_last word.
module rr_arb_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready
);
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_ch;
  logic [CW-1:0]    r_ptr;
  logic             w_load;
  logic             w_any;
  logic             w_xfer;
  logic             w_ptr_upd;
  logic [CW-1:0]    w_gnt;
  logic [CW-1:0]    w_next;
  logic [CW:0]      w_idx;
`ifdef RR_MUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_lock_ch;
`endif

  assign w_load = !r_out_valid || out_ready;

  // Descending scan so the channel closest to r_ptr (in wrap order) wins last.
  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_idx = (CW+1)'(r_ptr) + (CW+1)'(k);
      w_idx = (w_idx >= (CW+1)'(N_CH)) ? w_idx - (CW+1)'(N_CH) : w_idx;
      if (in_valid[w_idx[CW-1:0]]) begin
        w_gnt = w_idx[CW-1:0];
        w_any = 1'b1;
      end
    end
`ifdef RR_MUX_LOCK_EN
    if (r_state == LOCKED) begin
      w_gnt = r_lock_ch;
      w_any = in_valid[r_lock_ch];
    end
`endif
  end

  assign w_xfer   = w_load && w_any && !rst;
  assign w_next   = (w_gnt == CW'(N_CH - 1)) ? '0 : w_gnt + 1'b1;
  assign in_ready = w_xfer ? (N_CH'(1) << w_gnt) : '0;

`ifdef RR_MUX_LOCK_EN
  assign w_ptr_upd = w_xfer && in_last[w_gnt];

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) w_state_nxt = in_last[w_gnt] ? IDLE : LOCKED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_xfer ? w_gnt : r_lock_ch;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^in_last;
  assign w_ptr_upd = w_xfer;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[int'(w_gnt)*WIDTH +: WIDTH];
        r_out_ch    <= w_gnt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_ptr_upd) r_ptr <= w_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of rr_arb_mux at N_CH=4, WIDTH=8.
module tb_rr_arb_mux;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_ch [5];
  int          exp_dat [5];

  rr_arb_mux #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef RR_MUX_LOCK_EN
    exp_ch  = '{1, 1, 1, 3, 0};
    exp_dat = '{'h11, 'h11, 'h11, 'hA3, 'hA0};
`else
    exp_ch  = '{1, 3, 0, 1, 3};
    exp_dat = '{'h11, 'hA3, 'hA0, 'h11, 'hA3};
`endif
    rst = 1'b1;
    in_valid = 4'b0000;
    in_data = 32'hA3A2A1A0;
    in_last = 4'b1111;
    out_ready = 1'b1;
    #2;
    in_valid = 4'b1111;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_out_valid", 32'(out_valid), 1);
      chk("rr_out_ch", 32'(out_ch), 32'(i % 4));
      chk("rr_out_data", 32'(out_data), 32'(8'hA0 + 8'(i % 4)));
    end
    in_valid = 4'b0001;
    #1;
    chk("wrap_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("wrap_out_ch", 32'(out_ch), 0);
    chk("wrap_out_data", 32'(out_data), 32'hA0);
    in_valid = 4'b1111;
    #1;
    chk("wrap_ptr_next", 32'(in_ready), 32'h2);
    in_valid = 4'b0000;
    step();
    chk("drain_out_valid", 32'(out_valid), 0);
    in_data[23:16] = 8'h5C;
    in_valid = 4'b0100;
    out_ready = 1'b0;
    #1;
    chk("stall_first_ready", 32'(in_ready), 32'h4);
    step();
    chk("stall_cap_ch", 32'(out_ch), 2);
    in_data[23:16] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 0);
      step();
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_data", 32'(out_data), 32'h5C);
      chk("stall_out_ch", 32'(out_ch), 2);
    end
    in_valid = 4'b0000;
    out_ready = 1'b1;
    step();
    chk("stall_release", 32'(out_valid), 0);
    in_valid = 4'b0010;
    #2;
    in_valid = 4'b0000;
    step();
    chk("withdraw_out_valid", 32'(out_valid), 0);
    in_valid = 4'b0001;
    out_ready = 1'b0;
    step();
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    chk("pre_rst_out_ch", 32'(out_ch), 0);
    in_valid = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    rst = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("post_rst_out_ch", 32'(out_ch), 0);
    chk("post_rst_out_data", 32'(out_data), 32'hA0);
    in_data[15:8] = 8'h11;
    in_valid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      in_last = (i == 2) ? 4'b1011 : 4'b1001;
      step();
      chk("pkt_out_ch", 32'(out_ch), 32'(exp_ch[i]));
      chk("pkt_out_data", 32'(out_data), 32'(exp_dat[i]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
